dp_tap_ctrl: RTL and testbench
==============================

Name: dp_tap_ctrl

Overview:
IEEE 1149.1 TAP controller for the debug port. It oversamples the external tck/tms/tdi pins in the iclk domain and runs the 16-state TAP FSM. It holds the instruction register and generates the single-cycle strobes (clock_dr, update_dr, ...) that sequence the data registers such as the bypass register. It also drives tdo from the IR chain or from the externally muxed DR chain output.

Parameters:
IR_W, 4, instruction register width (>=2)
IR_RST, 4'h1, ir_out value after reset / Test-Logic-Reset (IDCODE)
SYNC_STAGES, 2, synchronizer depth on tck/tms/tdi (>=2)

Ports:
iclk  in  1  internal clock; must be >=4x tck frequency
iresetn  in  1  internal reset
tck  in  1  JTAG test clock (asynchronous to iclk)
tms  in  1  JTAG mode select
tdi  in  1  JTAG data in
tdo  out  1  JTAG data out
tdo_en  out  1  tdo output enable
dr_sdo  in  1  serial output of the DR currently selected by ir_out
sdi  out  1  synchronized tdi, fed to all DR sdi inputs
ir_out  out  IR_W  current instruction
clock_dr  out  1  one-iclk pulse: DR capture/shift
capture_dr  out  1  level, state == Capture-DR
shift_dr  out  1  level, state == Shift-DR
update_dr  out  1  one-iclk pulse: DR update
tlr  out  1  level, state == Test-Logic-Reset

Behaviour:
- Reset: iclk domain clocked by iclk; iresetn is asynchronous, active-low.
- Reset values: FSM = Test-Logic-Reset; ir_out = IR_RST; IR shift reg = 0; tdo = 0; tdo_en = 0; all strobes = 0; tlr = 1; synchronizers = 0.
- tck, tms, tdi pass through SYNC_STAGES flops. tck_rise/tck_fall are one-cycle pulses from the last sync stage vs. its delayed copy. sdi = synced tdi.
- FSM advances only on a tck_rise cycle, using the synced tms of the same cycle. Encoding is 4-bit, registered.
- Transitions are given as tms=0 / tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - CapIR: ShIR / Ex1IR
  - ShIR: ShIR / Ex1IR
  - Ex1IR: PauseIR / UpdIR
  - PauseIR: PauseIR / Ex2IR
  - Ex2IR: ShIR / UpdIR
  - UpdIR: RTI / SelDR
- Five consecutive tck_rise with tms=1 reach TLR from any state.
- clock_dr = tck_rise & (state ∈ {CapDR, ShDR}), evaluated on the state before the transition.
- update_dr = tck_fall & state == UpdDR.
- capture_dr, shift_dr and tlr are combinational decodes of the registered state.
- IR shift reg, on tck_rise:
  - CapIR: load {0..0,1} (LSB=1, others 0).
  - ShIR: shift right, sdi into MSB.
- ir_out loads the IR shift reg on tck_fall in UpdIR. It is forced to IR_RST whenever state == TLR.
- tdo/tdo_en are registered on tck_fall only:
  - ShDR: tdo = dr_sdo, tdo_en = 1.
  - ShIR: tdo = IR shift reg[0], tdo_en = 1.
  - Any other state: tdo holds, tdo_en = 0.
- tck_rise and tck_fall are never in the same cycle. A tck_rise in the cycle an update pulse would fire is impossible by construction.
- iresetn assertion mid-shift aborts immediately to reset values. No partial IR update.

Optional Feature:
Macro DP_TAP_TRST_EN.
- Defined: adds input trstn (1 bit, async JTAG reset). It is synchronized via SYNC_STAGES flops, and synced trstn == 0 forces the reset values above except synchronizers. It is held in TLR while low.
- Undefined: no trstn port. Reset is only via iresetn or the 5x tms=1 sequence.

Test Plan:
- Reset: iresetn low then high, no tck -> tlr=1, ir_out=4'h1, tdo_en=0, no strobes.
- From ShDR, five tck with tms=1 -> tlr=1 after 5th tck_rise; ir_out=4'h1 even if 4'hF was loaded before.
- IR load: TLR→RTI→SelDR→SelIR→CapIR→ShIR, shift tdi 1,1,1,1 (last with tms=1), UpdIR -> ir_out=4'hF at UpdIR tck_fall. Shifted-out tdo sequence = 1,0,0,0 (capture pattern).
- Bypass path: connect a 1-bit bypass register (sdi/clock_dr/dr_sdo), ir_out=4'hF, ShDR with tdi 1,0,1,1 -> tdo 0,1,0,1 on successive tck_fall. Exactly one clock_dr pulse per tck_rise in CapDR/ShDR.
- Pause: ShDR→Ex1DR→PauseDR (3 tck)→Ex2DR→ShDR -> no clock_dr and tdo_en=0 during pause. Shift then resumes correctly.
- Reset mid-operation: iresetn low during ShIR after 2 bits -> ir_out=4'h1, state TLR. Subsequent full IR load to 4'h2 yields ir_out=4'h2.

Source files
------------

// File: rtl/dp_tap_ctrl_if.sv
// DR-side bus of the debug-port TAP controller: serial data and DR sequencing strobes.
// The master modport is the TAP controller; the slave is the data-register block.
interface dp_tap_ctrl_if #(
  parameter int IR_W = 4
);
  logic            dr_sdo;
  logic            sdi;
  logic [IR_W-1:0] ir_out;
  logic            clock_dr;
  logic            capture_dr;
  logic            shift_dr;
  logic            update_dr;
  logic            tlr;

  modport master (
    input  dr_sdo,
    output sdi, ir_out, clock_dr, capture_dr, shift_dr, update_dr, tlr
  );

  modport slave (
    output dr_sdo,
    input  sdi, ir_out, clock_dr, capture_dr, shift_dr, update_dr, tlr
  );
endinterface

// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller oversampling tck/tms/tdi in the iclk domain.
// Optional macro DP_TAP_TRST_EN adds the asynchronous JTAG reset input trstn.
module dp_tap_ctrl #(
  parameter int              IR_W        = 4,
  parameter logic [IR_W-1:0] IR_RST      = IR_W'(1),
  parameter int              SYNC_STAGES = 2
) (
  input  logic iclk,
  input  logic iresetn,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
`ifdef DP_TAP_TRST_EN
  input  logic trstn,
`endif
  output logic tdo,
  output logic tdo_en,
  dp_tap_ctrl_if.master dr
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR,
    UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e state, next_state;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_d;
  logic                   tck_rise, tck_fall, tms_s, sdi_s;
  logic                   soft_rst;
  logic [IR_W-1:0]        ir_shift, ir_reg;
  logic                   clock_dr_c, update_dr_c, capture_dr_c, shift_dr_c, tlr_c;

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_d    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_d    <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_rise = tck_sync[SYNC_STAGES-1] & ~tck_d;
  assign tck_fall = ~tck_sync[SYNC_STAGES-1] & tck_d;
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign sdi_s    = tdi_sync[SYNC_STAGES-1];

`ifdef DP_TAP_TRST_EN
  logic [SYNC_STAGES-1:0] trstn_sync;

  // Synced trstn acts as a functional reset; the synchronizers themselves keep running.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) trstn_sync <= '0;
    else          trstn_sync <= {trstn_sync[SYNC_STAGES-2:0], trstn};
  end

  assign soft_rst = ~trstn_sync[SYNC_STAGES-1];
`else
  assign soft_rst = 1'b0;
`endif

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn)      state <= TLR;
    else if (soft_rst) state <= TLR;
    else if (tck_rise) state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = tms_s ? TLR      : RTI;
      RTI:      next_state = tms_s ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms_s ? EX1_DR   : SH_DR;
      SH_DR:    next_state = tms_s ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms_s ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = tms_s ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = tms_s ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms_s ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms_s ? EX1_IR   : SH_IR;
      SH_IR:    next_state = tms_s ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms_s ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = tms_s ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = tms_s ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // clock_dr looks at the state before the tck_rise transition takes effect.
  always_comb begin
    clock_dr_c   = 1'b0;
    update_dr_c  = 1'b0;
    capture_dr_c = (state == CAP_DR);
    shift_dr_c   = (state == SH_DR);
    tlr_c        = (state == TLR);
    if (!soft_rst) begin
      clock_dr_c  = tck_rise & ((state == CAP_DR) | (state == SH_DR));
      update_dr_c = tck_fall & (state == UPD_DR);
    end
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn)      ir_shift <= '0;
    else if (soft_rst) ir_shift <= '0;
    else if (tck_rise) begin
      if (state == CAP_IR)     ir_shift <= IR_W'(1);
      else if (state == SH_IR) ir_shift <= {sdi_s, ir_shift[IR_W-1:1]};
    end
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn)                          ir_reg <= IR_RST;
    else if (soft_rst || state == TLR)     ir_reg <= IR_RST;
    else if (tck_fall && state == UPD_IR)  ir_reg <= ir_shift;
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (soft_rst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (tck_fall) begin
      tdo_en <= 1'b0;
      if (state == SH_DR) begin
        tdo    <= dr.dr_sdo;
        tdo_en <= 1'b1;
      end else if (state == SH_IR) begin
        tdo    <= ir_shift[0];
        tdo_en <= 1'b1;
      end
    end
  end

  assign dr.sdi        = sdi_s;
  assign dr.ir_out     = (state == TLR) ? IR_RST : ir_reg;
  assign dr.clock_dr   = clock_dr_c;
  assign dr.update_dr  = update_dr_c;
  assign dr.capture_dr = capture_dr_c;
  assign dr.shift_dr   = shift_dr_c;
  assign dr.tlr        = tlr_c;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Directed bench for dp_tap_ctrl with a 1-bit bypass register on the DR side.
module tb_dp_tap_ctrl;
  logic iclk    = 1'b0;
  logic iresetn = 1'b0;
  logic tck     = 1'b0;
  logic tms     = 1'b0;
  logic tdi     = 1'b0;
  logic tdo, tdo_en;
  logic bypass_q;
  int   checks = 0;
  int   passes = 0;
  int   clk_dr_cnt = 0;
  int   upd_dr_cnt = 0;
  int   mark;

  dp_tap_ctrl_if #(.IR_W(4)) dr ();

  dp_tap_ctrl #(.IR_W(4), .IR_RST(4'h1), .SYNC_STAGES(2)) dut (
    .iclk    (iclk),
    .iresetn (iresetn),
    .tck     (tck),
    .tms     (tms),
    .tdi     (tdi),
`ifdef DP_TAP_TRST_EN
    .trstn   (1'b1),
`endif
    .tdo     (tdo),
    .tdo_en  (tdo_en),
    .dr      (dr.master)
  );

  always #5 iclk = ~iclk;

  // Bypass register: captures 0, shifts sdi on each clock_dr pulse.
  assign dr.dr_sdo = bypass_q;
  always @(posedge iclk or negedge iresetn) begin
    if (!iresetn)         bypass_q <= 1'b0;
    else if (dr.clock_dr) bypass_q <= dr.capture_dr ? 1'b0 : dr.sdi;
  end

  always @(posedge iclk) begin
    if (dr.clock_dr)  clk_dr_cnt <= clk_dr_cnt + 1;
    if (dr.update_dr) upd_dr_cnt <= upd_dr_cnt + 1;
  end

  task automatic applyStimulus(input logic tms_v, input logic tdi_v);
    @(negedge iclk);
    tms = tms_v;
    tdi = tdi_v;
    repeat (3) @(negedge iclk);
    tck = 1'b1;
    repeat (4) @(negedge iclk);
    tck = 1'b0;
    repeat (4) @(negedge iclk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Walks RTI -> IR path, shifting value LSB first, and returns to RTI.
  task automatic loadIr(input logic [3:0] value);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(i == 3, value[i]);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (4) @(negedge iclk);
    checkOutput("rst_tlr_held", {31'd0, dr.tlr}, 32'd1);
    checkOutput("rst_tdo_held", {31'd0, tdo}, 32'd0);
    iresetn = 1'b1;
    repeat (4) @(negedge iclk);
    checkOutput("rst_tlr", {31'd0, dr.tlr}, 32'd1);
    checkOutput("rst_ir_out", {28'd0, dr.ir_out}, 32'h1);
    checkOutput("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
    checkOutput("rst_strobes", {28'd0, dr.clock_dr, dr.update_dr, dr.capture_dr, dr.shift_dr}, 32'd0);

    // IR load of 4'hF with the capture pattern shifted out on tdo.
    applyStimulus(1'b0, 1'b0);
    checkOutput("rti_tlr_low", {31'd0, dr.tlr}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ir_tdo0", {30'd0, tdo_en, tdo}, 32'd3);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ir_tdo1", {30'd0, tdo_en, tdo}, 32'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ir_tdo2", {30'd0, tdo_en, tdo}, 32'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ir_tdo3", {30'd0, tdo_en, tdo}, 32'd2);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ex1ir_tdo_en", {31'd0, tdo_en}, 32'd0);
    checkOutput("ir_no_early_update", {28'd0, dr.ir_out}, 32'h1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ir_loaded_f", {28'd0, dr.ir_out}, 32'hF);
    applyStimulus(1'b0, 1'b0);

    // Bypass path: tdi 1,0,1,1 gives tdo 0,1,0,1.
    applyStimulus(1'b1, 1'b0);
    mark = clk_dr_cnt;
    applyStimulus(1'b0, 1'b0);
    checkOutput("capture_dr_level", {31'd0, dr.capture_dr}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("shift_dr_level", {31'd0, dr.shift_dr}, 32'd1);
    checkOutput("byp_tdo0", {30'd0, tdo_en, tdo}, 32'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("byp_tdo1", {30'd0, tdo_en, tdo}, 32'd3);
    applyStimulus(1'b0, 1'b0);
    checkOutput("byp_tdo2", {30'd0, tdo_en, tdo}, 32'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("byp_tdo3", {30'd0, tdo_en, tdo}, 32'd3);
    applyStimulus(1'b1, 1'b1);
    checkOutput("byp_clock_dr_count", clk_dr_cnt - mark, 32'd5);

    // Pause: no clock_dr, tdo_en low, then shifting resumes.
    mark = clk_dr_cnt;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("pause_tdo_en", {31'd0, tdo_en}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("pause_no_clock_dr", clk_dr_cnt - mark, 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("resume_tdo0", {30'd0, tdo_en, tdo}, 32'd3);
    applyStimulus(1'b0, 1'b0);
    checkOutput("resume_tdo1", {30'd0, tdo_en, tdo}, 32'd2);
    mark = upd_dr_cnt;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("update_dr_count", upd_dr_cnt - mark, 32'd1);
    applyStimulus(1'b0, 1'b0);

    // Five tms=1 from ShDR lands in TLR and restores IDCODE.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("shdr_ir_still_f", {28'd0, dr.ir_out}, 32'hF);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("tms4_not_tlr", {31'd0, dr.tlr}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("tms5_tlr", {31'd0, dr.tlr}, 32'd1);
    checkOutput("tms5_ir_idcode", {28'd0, dr.ir_out}, 32'h1);

    // iresetn mid ShIR aborts without a partial IR update.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    iresetn = 1'b0;
    repeat (3) @(negedge iclk);
    iresetn = 1'b1;
    repeat (3) @(negedge iclk);
    checkOutput("midrst_tlr", {31'd0, dr.tlr}, 32'd1);
    checkOutput("midrst_ir_out", {28'd0, dr.ir_out}, 32'h1);
    checkOutput("midrst_tdo", {30'd0, tdo_en, tdo}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    loadIr(4'h2);
    checkOutput("ir_loaded_2", {28'd0, dr.ir_out}, 32'h2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
